// File: rtl/tcm_stream_master_if.sv
// Command, write-stream, read-stream and TCM request signals of tcm_stream_master.
// The master modport is the initiator side; the slave modport is the loader/TCM environment side.
interface tcm_stream_master_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 15,
    parameter int unsigned LEN_WIDTH  = 13
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic                  cmd_write_i;
    logic [ADDR_WIDTH-1:0] cmd_addr_i;
    logic [LEN_WIDTH-1:0]  cmd_len_i;
    logic                  busy_o;
    logic                  done_o;

    logic                  s_valid_i;
    logic                  s_ready_o;
    logic [DATA_WIDTH-1:0] s_data_i;

    logic                  m_valid_o;
    logic                  m_ready_i;
    logic [DATA_WIDTH-1:0] m_data_o;

    logic                  tcm_en_o;
    logic                  tcm_we_o;
    logic [ADDR_WIDTH-1:0] tcm_addr_o;
    logic [BE_WIDTH-1:0]   tcm_be_o;
    logic [DATA_WIDTH-1:0] tcm_wdata_o;
    logic [DATA_WIDTH-1:0] tcm_rdata_i;

    modport master (
        input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_len_i,
        output cmd_ready_o, busy_o, done_o,
        input  s_valid_i, s_data_i,
        output s_ready_o,
        input  m_ready_i,
        output m_valid_o, m_data_o,
        output tcm_en_o, tcm_we_o, tcm_addr_o, tcm_be_o, tcm_wdata_o,
        input  tcm_rdata_i
    );

    modport slave (
        output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_len_i,
        input  cmd_ready_o, busy_o, done_o,
        output s_valid_i, s_data_i,
        input  s_ready_o,
        output m_ready_i,
        input  m_valid_o, m_data_o,
        input  tcm_en_o, tcm_we_o, tcm_addr_o, tcm_be_o, tcm_wdata_o,
        output tcm_rdata_i
    );
endinterface

// File: rtl/tcm_stream_master.sv
// Command-driven block mover between valid/ready streams and a single-port TCM.
// WRITE sinks the s_* stream into consecutive words; READ sources consecutive words onto m_*.
module tcm_stream_master #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 15,
    parameter int unsigned LEN_WIDTH  = 13
) (
    input  logic clk_i,
    input  logic rst_ni,
    tcm_stream_master_if.master bus
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(BE_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BE_WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_FIN} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic                  alive_q;

    logic [DATA_WIDTH-1:0] fifo_q [2];
    logic                  wr_ptr_q, rd_ptr_q;
    logic [1:0]            cnt_q;
    logic                  inflight_q;

    logic       cmd_ready, s_ready, m_valid;
    logic       cmd_fire, wr_fire, rd_issue, pop;
    logic [2:0] occ;

    // alive_q keeps the command port closed until the first clock after reset release
    assign cmd_ready = alive_q && (state_q == S_IDLE);
    assign s_ready   = (state_q == S_WRITE);
    assign m_valid   = (state_q == S_READ) && (cnt_q != 2'd0);
    assign cmd_fire  = bus.cmd_valid_i && cmd_ready;
    assign wr_fire   = bus.s_valid_i && s_ready;
    assign pop       = m_valid && bus.m_ready_i;

    // Words buffered or in flight once this cycle's pop retires; a new read needs a free slot
    assign occ       = 3'(cnt_q) + 3'(inflight_q) - 3'(pop);
    assign rd_issue  = (state_q == S_READ) && (rem_q != '0) && (occ < 3'd2);

    assign bus.cmd_ready_o = cmd_ready;
    assign bus.busy_o      = (state_q != S_IDLE);
    assign bus.done_o      = (state_q == S_FIN);
    assign bus.s_ready_o   = s_ready;
    assign bus.m_valid_o   = m_valid;
    assign bus.m_data_o    = fifo_q[rd_ptr_q];
    assign bus.tcm_en_o    = wr_fire || rd_issue;
    assign bus.tcm_we_o    = wr_fire;
    assign bus.tcm_addr_o  = addr_q;
    assign bus.tcm_be_o    = '1;
    assign bus.tcm_wdata_o = bus.s_data_i;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_fire) begin
                    addr_d = bus.cmd_addr_i & ALIGN_MASK;
                    rem_d  = bus.cmd_len_i;
                    if (bus.cmd_len_i == '0)   state_d = S_FIN;
                    else if (bus.cmd_write_i)  state_d = S_WRITE;
                    else                       state_d = S_READ;
                end
            end
            S_WRITE: begin
                if (wr_fire) begin
                    addr_d = addr_q + ADDR_STEP;
                    rem_d  = rem_q - LEN_WIDTH'(1);
                    if (rem_q == LEN_WIDTH'(1)) state_d = S_FIN;
                end
            end
            S_READ: begin
                if (rd_issue) begin
                    addr_d = addr_q + ADDR_STEP;
                    rem_d  = rem_q - LEN_WIDTH'(1);
                end
                // last word leaves once nothing is left to issue, nothing in flight, one buffered
                if ((rem_q == '0) && !inflight_q && (cnt_q == 2'd1) && pop) state_d = S_FIN;
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            alive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            alive_q <= 1'b1;
        end
    end

    // Read return path: rdata of the previous cycle's request is pushed into the 2-entry FIFO
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            cnt_q      <= 2'd0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= rd_issue;
            if (inflight_q) begin
                fifo_q[wr_ptr_q] <= bus.tcm_rdata_i;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            cnt_q <= cnt_q + 2'(inflight_q) - 2'(pop);
        end
    end
endmodule

// File: tb/tb_tcm_stream_master.sv
// Randomized bench for tcm_stream_master: behavioural TCM, reference word map and
// address arithmetic from the command rules, checked per scenario task.
module tb_tcm_stream_master;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 15;
    localparam int unsigned LW = 13;
    localparam int WORDS = 8192;
    // handshake cycle -> READ state (issue) -> TCM data -> FIFO output
    localparam int FIRST_RD_LAT = 3;
    localparam int BOUND = 400;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b1;

    tcm_stream_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

    tcm_stream_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural single-port TCM with one-cycle read latency
    logic [DW-1:0] tcm_mem [WORDS];
    always @(posedge clk_i) begin
        if (bus.tcm_en_o) begin
            if (bus.tcm_we_o) tcm_mem[bus.tcm_addr_o[AW-1:2]] <= bus.tcm_wdata_o;
            bus.tcm_rdata_i <= tcm_mem[bus.tcm_addr_o[AW-1:2]];
        end
    end

    logic [DW-1:0] ref_mem [int];
    logic [DW-1:0] tx_q [$];

    int            cyc = 0;
    int            acc_cyc, acc_cnt, outst, max_outst, stab_err, be_err, idle_en;
    logic [AW-1:0] wr_addr_q [$];
    logic [DW-1:0] wr_data_q [$];
    int            wr_cyc_q  [$];
    logic [AW-1:0] rd_addr_q [$];
    logic [DW-1:0] rx_q      [$];
    int            rx_cyc_q  [$];
    int            done_q    [$];
    logic          prev_mv, prev_mr;
    logic [DW-1:0] prev_md;

    // Passive monitor: samples each cycle mid-period and logs bus events
    always @(negedge clk_i) begin
        cyc++;
        if (!rst_ni) begin
            outst   = 0;
            prev_mv = 1'b0;
            prev_mr = 1'b0;
        end else begin
            if (bus.cmd_valid_i && bus.cmd_ready_o) begin acc_cyc = cyc; acc_cnt++; end
            if (bus.tcm_en_o && !bus.busy_o) idle_en++;
            if (bus.tcm_en_o && bus.tcm_we_o) begin
                wr_addr_q.push_back(bus.tcm_addr_o);
                wr_data_q.push_back(bus.tcm_wdata_o);
                wr_cyc_q.push_back(cyc);
                if (bus.tcm_be_o !== 4'hF) be_err++;
            end
            if (bus.tcm_en_o && !bus.tcm_we_o) begin
                rd_addr_q.push_back(bus.tcm_addr_o);
                outst++;
            end
            if (bus.m_valid_o && bus.m_ready_i) begin
                rx_q.push_back(bus.m_data_o);
                rx_cyc_q.push_back(cyc);
                outst--;
            end
            if (outst > max_outst) max_outst = outst;
            if (prev_mv && !prev_mr && (!bus.m_valid_o || bus.m_data_o !== prev_md)) stab_err++;
            prev_mv = bus.m_valid_o;
            prev_mr = bus.m_ready_i;
            prev_md = bus.m_data_o;
            if (bus.done_o) done_q.push_back(cyc);
        end
    end

    function automatic int word_idx(input logic [AW-1:0] base, input int i);
        return ((int'(base) / 4) + i) % WORDS;
    endfunction

    function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] base, input int i);
        return AW'(word_idx(base, i) * 4);
    endfunction

    // Issue one command and drive the streams until done_o (entered and left at posedge+1)
    task automatic run_cmd(input logic wr, input logic [AW-1:0] base, input int len,
                           input int mode, input bit junk);
        int  idx = 0;
        int  k = 0;
        bit  seen = 0;
        wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
        rd_addr_q.delete(); rx_q.delete(); rx_cyc_q.delete(); done_q.delete();
        acc_cnt = 0; max_outst = 0; stab_err = 0; be_err = 0; idle_en = 0;
        bus.cmd_valid_i = 1'b1;
        bus.cmd_write_i = wr;
        bus.cmd_addr_i  = base;
        bus.cmd_len_i   = LW'(len);
        @(posedge clk_i); #1;
        if (junk) begin
            bus.cmd_write_i = 1'($urandom);
            bus.cmd_addr_i  = AW'($urandom);
            bus.cmd_len_i   = LW'(1 + $urandom_range(0, 5));
        end else begin
            bus.cmd_valid_i = 1'b0;
        end
        while (!seen && k < BOUND) begin
            bus.s_valid_i = (mode == 0) ? 1'b1 : 1'($urandom);
            bus.s_data_i  = (idx < tx_q.size()) ? tx_q[idx] : DW'($urandom);
            case (mode)
                0:       bus.m_ready_i = 1'b1;
                1:       bus.m_ready_i = (k % 4 == 0) || (k % 4 == 3);
                default: bus.m_ready_i = 1'($urandom);
            endcase
            @(negedge clk_i);
            if (bus.s_valid_i && bus.s_ready_o) idx++;
            if (bus.done_o) seen = 1;
            @(posedge clk_i); #1;
            k++;
        end
        bus.cmd_valid_i = 1'b0;
        bus.s_valid_i   = 1'b0;
        bus.m_ready_i   = 1'b0;
        n_checks++;
        if (!seen) begin
            n_errors++;
            $display("FAIL cmd_timeout: done_o not seen within %0d cycles (wr=%0b len=%0d)", BOUND, wr, len);
        end
    endtask

    task automatic test_write_block(input logic [AW-1:0] base, input int len, input int vmode,
                                    input bit seq_data, input bit junk);
        tx_q.delete();
        for (int i = 0; i < len; i++) tx_q.push_back(seq_data ? DW'(32'hA0 + i) : DW'($urandom));
        run_cmd(1'b1, base, len, vmode, junk);
        n_checks++;
        if (acc_cnt != 1) begin n_errors++; $display("FAIL wr_accepts: got %0d expected 1", acc_cnt); end
        n_checks++;
        if (wr_addr_q.size() != len) begin
            n_errors++; $display("FAIL wr_count: got %0d expected %0d", wr_addr_q.size(), len);
        end
        for (int i = 0; i < len && i < wr_addr_q.size(); i++) begin
            n_checks++;
            if (wr_addr_q[i] !== exp_addr(base, i)) begin
                n_errors++; $display("FAIL wr_addr[%0d]: got %h expected %h", i, wr_addr_q[i], exp_addr(base, i));
            end
            n_checks++;
            if (wr_data_q[i] !== tx_q[i]) begin
                n_errors++; $display("FAIL wr_data[%0d]: got %h expected %h", i, wr_data_q[i], tx_q[i]);
            end
            if (vmode == 0) begin
                n_checks++;
                if (wr_cyc_q[i] != acc_cyc + 1 + i) begin
                    n_errors++; $display("FAIL wr_cycle[%0d]: got %0d expected %0d", i, wr_cyc_q[i], acc_cyc + 1 + i);
                end
            end
            ref_mem[word_idx(base, i)] = tx_q[i];
        end
        n_checks++;
        if (done_q.size() != 1 || wr_cyc_q.size() == 0 || done_q[0] != wr_cyc_q[$] + 1) begin
            n_errors++; $display("FAIL wr_done: pulses %0d, done cycle not one after last write", done_q.size());
        end
        n_checks++;
        if (be_err != 0 || rd_addr_q.size() != 0 || idle_en != 0) begin
            n_errors++; $display("FAIL wr_side: be_err=%0d reads=%0d idle_en=%0d expected all 0", be_err, rd_addr_q.size(), idle_en);
        end
    endtask

    task automatic test_read_block(input logic [AW-1:0] base, input int len, input int rmode);
        tx_q.delete();
        run_cmd(1'b0, base, len, rmode, 1'b0);
        n_checks++;
        if (acc_cnt != 1) begin n_errors++; $display("FAIL rd_accepts: got %0d expected 1", acc_cnt); end
        n_checks++;
        if (rx_q.size() != len || rd_addr_q.size() != len) begin
            n_errors++; $display("FAIL rd_count: words %0d issues %0d expected %0d", rx_q.size(), rd_addr_q.size(), len);
        end
        for (int i = 0; i < len && i < rx_q.size() && i < rd_addr_q.size(); i++) begin
            n_checks++;
            if (rx_q[i] !== ref_mem[word_idx(base, i)]) begin
                n_errors++; $display("FAIL rd_data[%0d]: got %h expected %h", i, rx_q[i], ref_mem[word_idx(base, i)]);
            end
            n_checks++;
            if (rd_addr_q[i] !== exp_addr(base, i)) begin
                n_errors++; $display("FAIL rd_addr[%0d]: got %h expected %h", i, rd_addr_q[i], exp_addr(base, i));
            end
            if (rmode == 0) begin
                n_checks++;
                if (rx_cyc_q[i] != acc_cyc + FIRST_RD_LAT + i) begin
                    n_errors++; $display("FAIL rd_cycle[%0d]: got %0d expected %0d", i, rx_cyc_q[i], acc_cyc + FIRST_RD_LAT + i);
                end
            end
        end
        n_checks++;
        if (done_q.size() != 1 || rx_cyc_q.size() == 0 || done_q[0] != rx_cyc_q[$] + 1) begin
            n_errors++; $display("FAIL rd_done: pulses %0d, done cycle not one after last handshake", done_q.size());
        end
        n_checks++;
        if (max_outst > 2 || stab_err != 0 || wr_addr_q.size() != 0 || idle_en != 0) begin
            n_errors++; $display("FAIL rd_flow: max_outst=%0d stab_err=%0d writes=%0d idle_en=%0d expected <=2,0,0,0",
                                 max_outst, stab_err, wr_addr_q.size(), idle_en);
        end
    endtask

    task automatic test_reset();
        #2 rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        n_checks++;
        if ({bus.cmd_ready_o, bus.busy_o, bus.done_o, bus.s_ready_o, bus.m_valid_o, bus.tcm_en_o, bus.tcm_we_o} !== 7'b0) begin
            n_errors++; $display("FAIL reset_outputs: got %b expected 0000000",
                {bus.cmd_ready_o, bus.busy_o, bus.done_o, bus.s_ready_o, bus.m_valid_o, bus.tcm_en_o, bus.tcm_we_o});
        end
        @(negedge clk_i) rst_ni = 1'b1;
        @(posedge clk_i); #1;
        bus.s_valid_i = 1'b1;
        #1;
        n_checks++;
        if (bus.cmd_ready_o !== 1'b1 || bus.busy_o !== 1'b0) begin
            n_errors++; $display("FAIL idle_after_reset: cmd_ready=%b busy=%b expected 1 0", bus.cmd_ready_o, bus.busy_o);
        end
        n_checks++;
        if (bus.s_ready_o !== 1'b0 || bus.tcm_en_o !== 1'b0) begin
            n_errors++; $display("FAIL idle_stream: s_ready=%b tcm_en=%b expected 0 0", bus.s_ready_o, bus.tcm_en_o);
        end
        bus.s_valid_i = 1'b0;
        @(posedge clk_i); #1;
    endtask

    task automatic test_zero_len_align();
        for (int w = 0; w < 2; w++) begin
            run_cmd(1'(w), 15'h0123, 0, 0, 1'b0);
            n_checks++;
            if (done_q.size() != 1 || acc_cnt != 1 || done_q[0] != acc_cyc + 1) begin
                n_errors++; $display("FAIL zero_len_done: pulses %0d accepts %0d expected 1 1 next cycle", done_q.size(), acc_cnt);
            end
            n_checks++;
            if (wr_addr_q.size() != 0 || rd_addr_q.size() != 0) begin
                n_errors++; $display("FAIL zero_len_access: writes %0d reads %0d expected 0 0", wr_addr_q.size(), rd_addr_q.size());
            end
        end
        test_write_block(15'h0103, 1, 0, 1'b0, 1'b0);
        n_checks++;
        if (wr_addr_q.size() == 0 || wr_addr_q[0] !== 15'h0100) begin
            n_errors++; $display("FAIL unaligned_addr: first write not at 0100");
        end
        test_read_block(15'h0101, 2, 0);
    endtask

    task automatic test_wrap();
        test_write_block(15'h7FFC, 2, 0, 1'b0, 1'b0);
        n_checks++;
        if (wr_addr_q.size() != 2 || wr_addr_q[1] !== 15'h0000) begin
            n_errors++; $display("FAIL wrap_addr: second write not at 0000");
        end
        test_read_block(15'h7FFC, 2, 0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            logic [AW-1:0] base;
            int len;
            base = AW'($urandom);
            len  = 1 + $urandom_range(0, 11);
            test_write_block(base, len, 1, 1'b0, 1'b0);
            test_read_block(base, len, 2);
        end
    endtask

    task automatic test_reset_mid_read();
        int dones = 0;
        test_write_block(15'h0400, 16, 1, 1'b0, 1'b0);
        bus.cmd_valid_i = 1'b1; bus.cmd_write_i = 1'b0;
        bus.cmd_addr_i  = 15'h0400; bus.cmd_len_i = LW'(16);
        bus.m_ready_i   = 1'b1;
        @(posedge clk_i); #1;
        bus.cmd_valid_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        n_checks++;
        if ({bus.cmd_ready_o, bus.busy_o, bus.done_o, bus.s_ready_o, bus.m_valid_o, bus.tcm_en_o, bus.tcm_we_o} !== 7'b0) begin
            n_errors++; $display("FAIL async_reset_outputs: got %b expected 0000000",
                {bus.cmd_ready_o, bus.busy_o, bus.done_o, bus.s_ready_o, bus.m_valid_o, bus.tcm_en_o, bus.tcm_we_o});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            if (bus.done_o !== 1'b0) dones++;
        end
        n_checks++;
        if (dones != 0) begin n_errors++; $display("FAIL reset_done: got %0d done cycles expected 0", dones); end
        bus.m_ready_i = 1'b0;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        test_read_block(15'h0400, 16, 2);
    endtask

    initial begin
        bus.cmd_valid_i = 1'b0; bus.cmd_write_i = 1'b0;
        bus.cmd_addr_i  = '0;   bus.cmd_len_i   = '0;
        bus.s_valid_i   = 1'b0; bus.s_data_i    = '0;
        bus.m_ready_i   = 1'b0;
        test_reset();
        test_write_block(15'h0100, 4, 0, 1'b1, 1'b0);
        test_read_block(15'h0100, 4, 0);
        test_write_block(15'h0200, 8, 1, 1'b0, 1'b0);
        test_read_block(15'h0200, 8, 1);
        test_wrap();
        test_zero_len_align();
        test_write_block(15'h0600, 6, 1, 1'b0, 1'b1);
        test_random();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
